// File: rtl/rf_write_arbiter_if.sv
// Bundle for the shared register-file write port. The master side is the set of writeback
// requesters (and the regfile observing the port); the slave side is the arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 16
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [DW-1:0]        wd3;
  logic [1:0]           grant_id;
  logic [(1<<AW)-1:0]   pending_mask;
  logic [CW-1:0]        wr_count;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, we3, wa3, wd3, grant_id, pending_mask, wr_count
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, we3, wa3, wd3, grant_id, pending_mask, wr_count
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU (0), load unit (1) and
// mul/div unit (2). Each requester has a one-entry holding register; the winner is moved into
// a registered write-port stage. A mask of outstanding destinations is exported for hazards.
module rf_write_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 16
) (
  input logic              clk,
  input logic              reset_n,
  rf_write_arbiter_if.slave bus
);

  localparam logic [1:0] NoGrant = 2'd3;

  // Holding registers
  logic [NREQ-1:0] r_hold_valid;
  logic [AW-1:0]   r_hold_addr [NREQ];
  logic [DW-1:0]   r_hold_data [NREQ];

  // Round-robin pointer: index of the last winner
  logic [1:0]      r_last;

  // Write-port stage
  logic            r_we3;
  logic [AW-1:0]   r_wa3;
  logic [DW-1:0]   r_wd3;
  logic [1:0]      r_grant_id;
  logic [CW-1:0]   r_wr_count;

  logic [NREQ-1:0]     w_grant;
  logic                w_gnt_any;
  logic [1:0]          w_gnt_idx;
  logic [1:0]          w_cand;
  logic [NREQ-1:0]     w_xfer;
  logic [(1<<AW)-1:0]  w_pending;
  logic [AW-1:0]       w_gnt_addr;
  logic [DW-1:0]       w_gnt_data;

  // (base + step) mod 3 for base in 0..2, step in 1..3
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Arbitration: scan last+1, last+2, last+3 and grant the first held entry
  always_comb begin
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = 2'd0;
    w_cand    = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      w_cand = rr_idx(r_last, 2'(k));
      if (!w_gnt_any && r_hold_valid[w_cand]) begin
        w_gnt_any        = 1'b1;
        w_gnt_idx        = w_cand;
        w_grant[w_cand]  = 1'b1;
      end
    end
  end

  assign w_gnt_addr = r_hold_addr[w_gnt_idx];
  assign w_gnt_data = r_hold_data[w_gnt_idx];

  // A slot can accept when empty or when it is being drained this cycle
  assign bus.req_ready = ~r_hold_valid | w_grant;
  assign w_xfer        = bus.req_valid & bus.req_ready;

  // Holding registers: capture on transfer, clear when granted with no refill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_hold_addr[i] <= '0;
        r_hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_xfer[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_addr[i]  <= bus.req_addr[i*AW +: AW];
          r_hold_data[i]  <= bus.req_data[i*DW +: DW];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances only on a grant; reset makes requester 0 top priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 2'd2;
    end else if (w_gnt_any) begin
      r_last <= w_gnt_idx;
    end
  end

  // Write-port stage; writes to r0 occupy the port slot but never assert we3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we3      <= 1'b0;
      r_wa3      <= '0;
      r_wd3      <= '0;
      r_grant_id <= NoGrant;
      r_wr_count <= '0;
    end else if (w_gnt_any) begin
      r_we3      <= (w_gnt_addr != '0);
      r_wa3      <= w_gnt_addr;
      r_wd3      <= w_gnt_data;
      r_grant_id <= w_gnt_idx;
      if (w_gnt_addr != '0) r_wr_count <= r_wr_count + 1'b1;
    end else begin
      r_we3      <= 1'b0;
      r_grant_id <= NoGrant;
    end
  end

  // Outstanding destinations: held entries plus the write on the port; r0 never pends
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_hold_valid[i]) w_pending[r_hold_addr[i]] = 1'b1;
    end
    if (r_we3) w_pending[r_wa3] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign bus.we3          = r_we3;
  assign bus.wa3          = r_wa3;
  assign bus.wd3          = r_wd3;
  assign bus.grant_id     = r_grant_id;
  assign bus.pending_mask = w_pending;
  assign bus.wr_count     = r_wr_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a negedge-sampling register file model.
module tb_rf_write_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: commits the write port on the falling edge
  logic [31:0] rf_model [32];
  always @(negedge clk) begin
    if (bus.we3) rf_model[bus.wa3] <= bus.wd3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_reqs();
    #12;
    checks++;
    if (bus.we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %0b want 0", bus.we3); end
    checks++;
    if (bus.wa3 !== 5'd0 || bus.wd3 !== 32'd0) begin
      errors++; $display("FAIL reset_port got wa3=%0d wd3=%h want 0/0", bus.wa3, bus.wd3);
    end
    checks++;
    if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d want 3", bus.grant_id); end
    checks++;
    if (bus.wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.wr_count); end
    checks++;
    if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b want 111", bus.req_ready); end
    checks++;
    if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL reset_pending got %h want 0", bus.pending_mask); end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(1, 5'd5, 32'hDEADBEEF);
    checks++;
    if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL single_ready0 got %b want 111", bus.req_ready); end
    tick();
    clear_reqs();
    checks++;
    if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL single_ready1 got %b want 111", bus.req_ready); end
    checks++;
    if (bus.pending_mask !== 32'h20 || bus.we3 !== 1'b0) begin
      errors++; $display("FAIL single_held got pm=%h we3=%0b want 20/0", bus.pending_mask, bus.we3);
    end
    tick();
    checks++;
    if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd5 || bus.wd3 !== 32'hDEADBEEF || bus.grant_id !== 2'd1) begin
      errors++;
      $display("FAIL single_port got we3=%0b wa3=%0d wd3=%h gid=%0d want 1/5/deadbeef/1",
               bus.we3, bus.wa3, bus.wd3, bus.grant_id);
    end
    checks++;
    if (bus.wr_count !== 16'd1 || bus.pending_mask !== 32'h20) begin
      errors++; $display("FAIL single_count got cnt=%0d pm=%h want 1/20", bus.wr_count, bus.pending_mask);
    end
    tick();
    checks++;
    if (rf_model[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf got %h want deadbeef", rf_model[5]); end
    checks++;
    if (bus.we3 !== 1'b0 || bus.grant_id !== 2'd3 || bus.pending_mask !== 32'd0) begin
      errors++; $display("FAIL single_idle got we3=%0b gid=%0d pm=%h want 0/3/0",
                         bus.we3, bus.grant_id, bus.pending_mask);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gid [4];
    logic [4:0]  exp_wa  [4];
    logic [2:0]  exp_rdy [4];
    logic [31:0] exp_pm  [4];
    exp_gid = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_wa  = '{5'd1, 5'd2, 5'd3, 5'd3};
    exp_rdy = '{3'b011, 3'b111, 3'b111, 3'b111};
    exp_pm  = '{32'h0E, 32'h0C, 32'h08, 32'h00};
    do_reset();
    set_req(0, 5'd1, 32'h1111_0001);
    set_req(1, 5'd2, 32'h2222_0002);
    set_req(2, 5'd3, 32'h3333_0003);
    tick();
    clear_reqs();
    checks++;
    if (bus.req_ready !== 3'b001 || bus.pending_mask !== 32'h0E) begin
      errors++; $display("FAIL cont_held got rdy=%b pm=%h want 001/0e", bus.req_ready, bus.pending_mask);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (bus.grant_id !== exp_gid[c] || bus.wa3 !== exp_wa[c] || bus.req_ready !== exp_rdy[c]
          || bus.pending_mask !== exp_pm[c] || bus.we3 !== (c < 3)) begin
        errors++;
        $display("FAIL cont_cycle%0d got gid=%0d wa3=%0d rdy=%b pm=%h we3=%0b want %0d/%0d/%b/%h/%0b",
                 c, bus.grant_id, bus.wa3, bus.req_ready, bus.pending_mask, bus.we3,
                 exp_gid[c], exp_wa[c], exp_rdy[c], exp_pm[c], (c < 3));
      end
    end
    checks++;
    if (bus.wr_count !== 16'd3) begin errors++; $display("FAIL cont_count got %0d want 3", bus.wr_count); end
  endtask

  task automatic test_streaming();
    int n0;
    int n2;
    logic [1:0] exp;
    n0 = 0;
    n2 = 0;
    do_reset();
    set_req(0, 5'd10, 32'hA0A0_0000);
    set_req(2, 5'd20, 32'hC2C2_0000);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 10) clear_reqs();
      if (c >= 2) begin
        exp = (c == 13) ? 2'd3 : ((c % 2 == 0) ? 2'd0 : 2'd2);
        checks++;
        if (bus.grant_id !== exp) begin
          errors++; $display("FAIL stream_edge%0d got gid=%0d want %0d", c, bus.grant_id, exp);
        end
        if (c <= 11 && bus.grant_id == 2'd0) n0++;
        if (c <= 11 && bus.grant_id == 2'd2) n2++;
      end
    end
    checks++;
    if (n0 != 5 || n2 != 5) begin errors++; $display("FAIL stream_share got %0d/%0d want 5/5", n0, n2); end
    checks++;
    if (bus.wr_count !== 16'd11) begin errors++; $display("FAIL stream_count got %0d want 11", bus.wr_count); end
  endtask

  task automatic test_r0_write();
    do_reset();
    set_req(2, 5'd0, 32'h0000_1234);
    tick();
    clear_reqs();
    checks++;
    if (bus.pending_mask !== 32'd0) begin errors++; $display("FAIL r0_held_pm got %h want 0", bus.pending_mask); end
    tick();
    checks++;
    if (bus.we3 !== 1'b0 || bus.grant_id !== 2'd2 || bus.wr_count !== 16'd0
        || bus.pending_mask !== 32'd0) begin
      errors++; $display("FAIL r0_port got we3=%0b gid=%0d cnt=%0d pm=%h want 0/2/0/0",
                         bus.we3, bus.grant_id, bus.wr_count, bus.pending_mask);
    end
    tick();
    checks++;
    if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL r0_after got gid=%0d want 3", bus.grant_id); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 5'd4, 32'hAAAA_0004);
    set_req(1, 5'd5, 32'hAAAA_0005);
    set_req(2, 5'd6, 32'hAAAA_0006);
    tick();
    set_req(1, 5'd9, 32'hBBBB_0009);
    tick();
    clear_reqs();
    checks++;
    if (bus.we3 !== 1'b1 || bus.wa3 !== 5'd4) begin
      errors++; $display("FAIL mid_pre got we3=%0b wa3=%0d want 1/4", bus.we3, bus.wa3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.we3 !== 1'b0 || bus.pending_mask !== 32'd0 || bus.grant_id !== 2'd3
        || bus.req_ready !== 3'b111) begin
      errors++; $display("FAIL mid_async got we3=%0b pm=%h gid=%0d rdy=%b want 0/0/3/111",
                         bus.we3, bus.pending_mask, bus.grant_id, bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_model[4] === 32'hAAAA_0004) begin
      errors++; $display("FAIL mid_rf got %h want not aaaa0004", rf_model[4]);
    end
    reset_n = 1'b1;
    tick();
    set_req(0, 5'd11, 32'h0B0B_0011);
    set_req(1, 5'd12, 32'h0B0B_0012);
    set_req(2, 5'd13, 32'h0B0B_0013);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (bus.grant_id !== 2'd0 || bus.wa3 !== 5'd11) begin
      errors++; $display("FAIL mid_first got gid=%0d wa3=%0d want 0/11", bus.grant_id, bus.wa3);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int sent;
    int budget;
    sent = 0;
    budget = 0;
    do_reset();
    while (sent < 65536 && budget < 70000) begin
      set_req(0, 5'd7, 32'(sent));
      if (bus.req_ready[0]) begin
        tick();
        sent++;
      end else begin
        tick();
      end
      budget++;
    end
    clear_reqs();
    checks++;
    if (sent != 65536) begin errors++; $display("FAIL wrap_budget got %0d accepts want 65536", sent); end
    checks++;
    if (bus.wr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", bus.wr_count); end
    tick();
    checks++;
    if (bus.wr_count !== 16'h0000 || bus.wd3 !== 32'd65535 || bus.we3 !== 1'b1) begin
      errors++; $display("FAIL wrap_count got cnt=%h wd3=%0d we3=%0b want 0/65535/1",
                         bus.wr_count, bus.wd3, bus.we3);
    end
    tick();
    checks++;
    if (rf_model[7] !== 32'd65535) begin errors++; $display("FAIL wrap_rf got %0d want 65535", rf_model[7]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    clear_reqs();
    test_reset();
    test_single_write();
    test_contention();
    test_streaming();
    test_r0_write();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
